// File: rtl/i2c_txn_scheduler_if.sv
// Bus between the transaction scheduler and one i2c_master instance.
// The scheduler side drives the transaction descriptor and ena; the
// master side returns busy, ack_error, progress and read data.
interface i2c_txn_scheduler_if;
  logic        m_ena;
  logic [6:0]  m_addr;
  logic        m_rw;
  logic [31:0] m_data_wr;
  logic [7:0]  m_nbytes;
  logic        m_read_only;
  logic        m_busy;
  logic        m_ack_error;
  logic [7:0]  m_byte_counter;
  logic [31:0] m_data_rd;
  logic        m_fifo_write_ack;

  modport master (
    output m_ena, m_addr, m_rw, m_data_wr, m_nbytes, m_read_only,
    input  m_busy, m_ack_error, m_byte_counter, m_data_rd, m_fifo_write_ack
  );

  modport slave (
    input  m_ena, m_addr, m_rw, m_data_wr, m_nbytes, m_read_only,
    output m_busy, m_ack_error, m_byte_counter, m_data_rd, m_fifo_write_ack
  );
endinterface

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler sharing one i2c_master between N_REQ requesters.
// A winner's descriptor is latched when it is picked in IDLE, the master is
// driven through START/RUN/DRAIN, read words are forwarded tagged with the
// owner, and a one-cycle done pulse carries ok / ack_error / timeout status.
module i2c_txn_scheduler #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [7*N_REQ-1:0]    req_addr,
  input  logic [N_REQ-1:0]      req_rw,
  input  logic [32*N_REQ-1:0]   req_data,
  input  logic [8*N_REQ-1:0]    req_nbytes,
  input  logic [N_REQ-1:0]      req_read_only,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      done,
  output logic [1:0]            status,
  output logic [31:0]           rd_data,
  output logic                  rd_valid,
  output logic [2:0]            rd_owner,
  i2c_txn_scheduler_if.master   m
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] DRAIN = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ABORT = 3'd6;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ACK_ERR = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;

  localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
  // timer_r counts active cycles after LOAD; together with the LOAD cycle and
  // the current cycle, reaching this value means ABORT lands exactly
  // TIMEOUT_CYCLES cycles after LOAD.
  localparam logic [TW-1:0] TIMER_LIMIT = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);
  localparam logic [3:0] N_REQ_W  = 4'(N_REQ);

  logic [2:0]    state_r;
  logic [2:0]    rr_ptr_r;
  logic [2:0]    winner_r;
  logic [TW-1:0] timer_r;
  logic          ack_r;
  logic          fwa_d_r;
  logic          ena_r;
  logic [6:0]    addr_r;
  logic          rw_r;
  logic [31:0]   data_wr_r;
  logic [7:0]    nbytes_q;
  logic          read_only_r;

  logic [7:0]    req_a;
  logic [6:0]    addr_a    [8];
  logic          rw_a      [8];
  logic [31:0]   data_a    [8];
  logic [7:0]    nbytes_a  [8];
  logic          ro_a      [8];

  logic [2:0]    pick_s;
  logic          found_s;
  logic          active_s;
  logic          timeout_s;
  logic          ack_hit_s;
  logic          rd_edge_s;
  logic [7:0]    pick_hot_s;
  logic [7:0]    win_hot_s;
  logic [2:0]    next_ptr_s;

  // Requester slices spread into 8-entry tables so a 3-bit index always fits.
  for (genvar g = 0; g < 8; g++) begin : g_slice
    if (g < N_REQ) begin : g_on
      assign req_a[g]    = req[g];
      assign addr_a[g]   = req_addr[7*g +: 7];
      assign rw_a[g]     = req_rw[g];
      assign data_a[g]   = req_data[32*g +: 32];
      assign nbytes_a[g] = req_nbytes[8*g +: 8];
      assign ro_a[g]     = req_read_only[g];
    end else begin : g_off
      assign req_a[g]    = 1'b0;
      assign addr_a[g]   = 7'd0;
      assign rw_a[g]     = 1'b0;
      assign data_a[g]   = 32'd0;
      assign nbytes_a[g] = 8'd0;
      assign ro_a[g]     = 1'b0;
    end
  end

  assign active_s   = (state_r == START) || (state_r == RUN) || (state_r == DRAIN);
  assign timeout_s  = active_s && (timer_r >= TIMER_LIMIT);
  assign ack_hit_s  = ((state_r == RUN) || (state_r == DRAIN)) && m.m_ack_error;
  assign rd_edge_s  = active_s && m.m_fifo_write_ack && !fwa_d_r;
  assign pick_hot_s = 8'd1 << pick_s;
  assign win_hot_s  = 8'd1 << winner_r;
  assign next_ptr_s = (winner_r == LAST_IDX) ? 3'd0 : (winner_r + 3'd1);

  assign m.m_ena       = ena_r;
  assign m.m_addr      = addr_r;
  assign m.m_rw        = rw_r;
  assign m.m_data_wr   = data_wr_r;
  assign m.m_nbytes    = nbytes_q;
  assign m.m_read_only = read_only_r;

  // Round-robin pick: first pending request scanning upward from rr_ptr.
  always_comb begin
    logic [3:0] idx;
    pick_s  = rr_ptr_r;
    found_s = 1'b0;
    idx     = 4'd0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr_r} + 4'(i);
      idx = (idx >= N_REQ_W) ? (idx - N_REQ_W) : idx;
      if (!found_s && req_a[idx[2:0]]) begin
        pick_s  = idx[2:0];
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Transaction FSM: descriptor latch, master sequencing, grant/done/status.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      rr_ptr_r    <= 3'd0;
      winner_r    <= 3'd0;
      ena_r       <= 1'b0;
      addr_r      <= 7'd0;
      rw_r        <= 1'b0;
      data_wr_r   <= 32'd0;
      nbytes_q    <= 8'd0;
      read_only_r <= 1'b0;
      grant       <= '0;
      done        <= '0;
      status      <= ST_OK;
    end else begin
      done   <= '0;
      status <= ST_OK;
      case (state_r)
        IDLE: begin
          if (found_s) begin
            winner_r    <= pick_s;
            grant       <= pick_hot_s[N_REQ-1:0];
            addr_r      <= addr_a[pick_s];
            rw_r        <= rw_a[pick_s];
            data_wr_r   <= data_a[pick_s];
            nbytes_q    <= nbytes_a[pick_s];
            read_only_r <= ro_a[pick_s];
            state_r     <= LOAD;
          end
        end
        LOAD: begin
          if (nbytes_q == 8'd0) begin
            grant    <= '0;
            done     <= win_hot_s[N_REQ-1:0];
            status   <= ST_OK;
            rr_ptr_r <= next_ptr_s;
            state_r  <= DONE;
          end else begin
            ena_r   <= 1'b1;
            state_r <= START;
          end
        end
        START: begin
          if (timeout_s) begin
            ena_r   <= 1'b0;
            state_r <= ABORT;
          end else if (m.m_busy) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (timeout_s) begin
            ena_r   <= 1'b0;
            state_r <= ABORT;
          end else if (m.m_byte_counter >= nbytes_q) begin
            ena_r   <= 1'b0;
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          if (timeout_s) begin
            ena_r   <= 1'b0;
            state_r <= ABORT;
          end else if (!m.m_busy) begin
            grant    <= '0;
            done     <= win_hot_s[N_REQ-1:0];
            status   <= (ack_r || ack_hit_s) ? ST_ACK_ERR : ST_OK;
            rr_ptr_r <= next_ptr_s;
            state_r  <= DONE;
          end
        end
        ABORT: begin
          ena_r    <= 1'b0;
          grant    <= '0;
          done     <= win_hot_s[N_REQ-1:0];
          status   <= ST_TIMEOUT;
          rr_ptr_r <= next_ptr_s;
          state_r  <= DONE;
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          ena_r   <= 1'b0;
          grant   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Watchdog timer and sticky ack_error flag, both restarted in LOAD.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timer_r <= '0;
      ack_r   <= 1'b0;
    end else if (state_r == LOAD) begin
      timer_r <= '0;
      ack_r   <= 1'b0;
    end else begin
      if (active_s) begin
        timer_r <= timer_r + TW'(1);
      end
      if (ack_hit_s) begin
        ack_r <= 1'b1;
      end
    end
  end

  // Read path: one rd_valid strobe per rising edge of fifo_write_ack while busy.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fwa_d_r  <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= 32'd0;
      rd_owner <= 3'd0;
    end else begin
      fwa_d_r <= m.m_fifo_write_ack;
      if (rd_edge_s) begin
        rd_valid <= 1'b1;
        rd_data  <= m.m_data_rd;
        rd_owner <= winner_r;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_txn_scheduler.sv
// Directed bench for i2c_txn_scheduler: the master side is driven by hand
// and every expected value below is worked out from the cycle-level behaviour.
module tb_i2c_txn_scheduler;
  logic         clock = 1'b0;
  logic         reset_n;
  logic [3:0]   req;
  logic [27:0]  req_addr;
  logic [3:0]   req_rw;
  logic [127:0] req_data;
  logic [31:0]  req_nbytes;
  logic [3:0]   req_read_only;
  logic [3:0]   grant;
  logic [3:0]   done;
  logic [1:0]   status;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic [2:0]   rd_owner;
  logic [3:0]   exp_g;
  int           tests = 0;
  int           fails = 0;

  i2c_txn_scheduler_if bus();

  i2c_txn_scheduler #(.N_REQ(4), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_addr(req_addr),
    .req_rw(req_rw), .req_data(req_data), .req_nbytes(req_nbytes),
    .req_read_only(req_read_only), .grant(grant), .done(done),
    .status(status), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_owner(rd_owner), .m(bus)
  );

  // 10 ns system clock.
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int i, input logic [6:0] a, input logic rw,
                          input logic [31:0] d, input logic [7:0] nb, input logic ro);
    req_addr[7*i +: 7]    = a;
    req_rw[i]             = rw;
    req_data[32*i +: 32]  = d;
    req_nbytes[8*i +: 8]  = nb;
    req_read_only[i]      = ro;
  endtask

  task automatic read_word(input logic [31:0] d, input logic [7:0] bc, input logic [2:0] owner);
    bus.m_data_rd        = d;
    bus.m_byte_counter   = bc;
    bus.m_fifo_write_ack = 1'b1;
    tick;
    check("rd_valid_hi", 32'(rd_valid), 32'(1'b1));
    check("rd_data", rd_data, d);
    check("rd_owner", 32'(rd_owner), 32'(owner));
    bus.m_fifo_write_ack = 1'b0;
    tick;
    check("rd_valid_lo", 32'(rd_valid), 32'(1'b0));
  endtask

  initial begin
    reset_n = 1'b0; req = 4'd0; req_addr = 28'd0; req_rw = 4'd0;
    req_data = 128'd0; req_nbytes = 32'd0; req_read_only = 4'd0;
    bus.m_busy = 1'b0; bus.m_ack_error = 1'b0; bus.m_byte_counter = 8'd0;
    bus.m_data_rd = 32'd0; bus.m_fifo_write_ack = 1'b0;

    // Reset state
    tick; tick;
    check("rst_grant", 32'(grant), 32'(4'd0));
    check("rst_done", 32'(done), 32'(4'd0));
    check("rst_status", 32'(status), 32'(2'd0));
    check("rst_rd_valid", 32'(rd_valid), 32'(1'b0));
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_m_ena", 32'(bus.m_ena), 32'(1'b0));
    check("rst_m_addr", 32'(bus.m_addr), 32'(7'd0));
    check("rst_m_data_wr", bus.m_data_wr, 32'd0);
    reset_n = 1'b1;

    // Read-ack edge while idle is dropped
    bus.m_fifo_write_ack = 1'b1;
    tick;
    check("idle_edge_dropped", 32'(rd_valid), 32'(1'b0));
    bus.m_fifo_write_ack = 1'b0;
    tick;

    // Fairness with all requesters held, zero-byte transactions
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'(1 << (k % 4));
      tick;
      check("fair_grant", 32'(grant), 32'(exp_g));
      check("fair_no_ena", 32'(bus.m_ena), 32'(1'b0));
      tick;
      check("fair_done", 32'(done), 32'(exp_g));
      check("fair_grant_clr", 32'(grant), 32'(4'd0));
      tick;
      check("fair_done_pulse", 32'(done), 32'(4'd0));
    end
    req = 4'd0;

    // Single 4-byte read on requester 1
    set_slot(1, 7'h68, 1'b1, 32'd0, 8'd4, 1'b0);
    req = 4'b0010;
    tick;
    check("rd_grant", 32'(grant), 32'(4'b0010));
    check("rd_m_addr", 32'(bus.m_addr), 32'(7'h68));
    check("rd_m_rw", 32'(bus.m_rw), 32'(1'b1));
    check("rd_m_nbytes", 32'(bus.m_nbytes), 32'(8'd4));
    check("rd_ena_not_yet", 32'(bus.m_ena), 32'(1'b0));
    req = 4'd0;
    tick;
    check("rd_ena_first", 32'(bus.m_ena), 32'(1'b1));
    bus.m_busy = 1'b1;
    tick;
    read_word(32'h11, 8'd1, 3'd1);
    read_word(32'h22, 8'd2, 3'd1);
    read_word(32'h33, 8'd3, 3'd1);
    check("rd_ena_held", 32'(bus.m_ena), 32'(1'b1));
    read_word(32'h44, 8'd4, 3'd1);
    check("rd_ena_drop", 32'(bus.m_ena), 32'(1'b0));
    check("rd_grant_drain", 32'(grant), 32'(4'b0010));
    bus.m_busy = 1'b0; bus.m_byte_counter = 8'd0;
    tick;
    check("rd_done", 32'(done), 32'(4'b0010));
    check("rd_status", 32'(status), 32'(2'b00));
    check("rd_addr_stable", 32'(bus.m_addr), 32'(7'h68));
    tick;
    check("rd_done_pulse", 32'(done), 32'(4'd0));

    // Write with ack error on requester 2
    set_slot(2, 7'h50, 1'b0, 32'hDEADBEEF, 8'd2, 1'b0);
    req = 4'b0100;
    tick;
    check("ae_grant", 32'(grant), 32'(4'b0100));
    check("ae_m_data_wr", bus.m_data_wr, 32'hDEADBEEF);
    check("ae_m_rw", 32'(bus.m_rw), 32'(1'b0));
    req = 4'd0;
    tick;
    bus.m_busy = 1'b1;
    tick;
    bus.m_ack_error = 1'b1; bus.m_byte_counter = 8'd1;
    tick;
    bus.m_ack_error = 1'b0; bus.m_byte_counter = 8'd2;
    tick;
    check("ae_ena_drop", 32'(bus.m_ena), 32'(1'b0));
    bus.m_busy = 1'b0; bus.m_byte_counter = 8'd0;
    tick;
    check("ae_done", 32'(done), 32'(4'b0100));
    check("ae_status", 32'(status), 32'(2'b01));
    tick;

    // Pointer now at 3: requesters 0 and 3 compete, 3 wins, flag cleared
    set_slot(0, 7'h10, 1'b0, 32'd0, 8'd0, 1'b0);
    set_slot(3, 7'h13, 1'b0, 32'd0, 8'd0, 1'b0);
    req = 4'b1001;
    tick;
    check("ptr3_grant", 32'(grant), 32'(4'b1000));
    req = 4'd0;
    tick;
    check("ptr3_done", 32'(done), 32'(4'b1000));
    check("ptr3_status", 32'(status), 32'(2'b00));
    tick;

    // Zero-byte transaction on requester 0
    req = 4'b0001;
    tick;
    check("nb0_grant", 32'(grant), 32'(4'b0001));
    req = 4'd0;
    tick;
    check("nb0_done", 32'(done), 32'(4'b0001));
    check("nb0_status", 32'(status), 32'(2'b00));
    check("nb0_no_ena", 32'(bus.m_ena), 32'(1'b0));
    tick;

    // Timeout with busy stuck; completion in the abort cycle loses
    req = 4'b0010;
    tick;
    check("to_grant", 32'(grant), 32'(4'b0010));
    req = 4'd0;
    tick;
    bus.m_busy = 1'b1;
    for (int i = 2; i <= 99; i++) tick;
    check("to_ena_99", 32'(bus.m_ena), 32'(1'b1));
    bus.m_byte_counter = 8'd4;
    tick;
    check("to_ena_100", 32'(bus.m_ena), 32'(1'b0));
    check("to_grant_abort", 32'(grant), 32'(4'b0010));
    tick;
    check("to_done", 32'(done), 32'(4'b0010));
    check("to_status", 32'(status), 32'(2'b10));
    bus.m_byte_counter = 8'd0; bus.m_busy = 1'b0;
    tick;
    check("to_done_pulse", 32'(done), 32'(4'd0));

    // Reset during RUN
    set_slot(2, 7'h52, 1'b1, 32'd0, 8'd4, 1'b0);
    req = 4'b0100;
    tick;
    check("mr_grant", 32'(grant), 32'(4'b0100));
    req = 4'd0;
    tick;
    bus.m_busy = 1'b1;
    tick;
    check("mr_ena_run", 32'(bus.m_ena), 32'(1'b1));
    reset_n = 1'b0;
    tick;
    check("mr_ena", 32'(bus.m_ena), 32'(1'b0));
    check("mr_grant_clr", 32'(grant), 32'(4'd0));
    check("mr_no_done", 32'(done), 32'(4'd0));
    reset_n = 1'b1; bus.m_busy = 1'b0;
    set_slot(1, 7'h61, 1'b0, 32'd0, 8'd0, 1'b0);
    req = 4'b0110;
    tick;
    check("mr_fresh_grant", 32'(grant), 32'(4'b0010));
    req = 4'd0;
    tick;
    check("mr_fresh_done", 32'(done), 32'(4'b0010));
    tick;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
